// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the integer register file's single write port.
// One registered output stage drives the register file; pending_o lets decode stall on in-flight destinations.
module regfile_wb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int REG_WIDTH = 64
) (
  input  logic                           clk_sys_i,
  input  logic                           rst_i,
  input  logic                           stall_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*5-1:0]           req_rd_i,
  input  logic [NUM_REQ*REG_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [4:0]                     rd_addr_o,
  output logic                           rd_wen_o,
  output logic [REG_WIDTH-1:0]           result_o,
  output logic [31:0]                    pending_o
);

  localparam int          PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0] NREQ = (PW+1)'(NUM_REQ);

  logic [4:0]           rd_arr   [NUM_REQ];
  logic [REG_WIDTH-1:0] data_arr [NUM_REQ];
  logic [31:0]          pend_arr [NUM_REQ];

  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 wen_q, wen_d;
  logic [4:0]           addr_q, addr_d;
  logic [REG_WIDTH-1:0] result_q, result_d;

  logic                 grant_any;
  logic [PW-1:0]        grant_idx;
  logic [PW:0]          cand_ext;
  logic [4:0]           sel_rd;
  logic [REG_WIDTH-1:0] sel_data;
  logic [31:0]          pend_all;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign rd_arr[gi]   = req_rd_i[5*gi +: 5];
      assign data_arr[gi] = req_data_i[REG_WIDTH*gi +: REG_WIDTH];
      assign pend_arr[gi] = req_valid_i[gi] ? (32'd1 << rd_arr[gi]) : 32'd0;
    end
  endgenerate

  // Scan starting at ptr_q, wrapping modulo NUM_REQ; first valid requester wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_ext  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_ext = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand_ext >= NREQ) cand_ext = cand_ext - NREQ;
      if (!grant_any && req_valid_i[cand_ext[PW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand_ext[PW-1:0];
      end
    end
    if (stall_i || rst_i) grant_any = 1'b0;
  end

  always_comb begin
    req_ready_o = '0;
    if (grant_any) req_ready_o[grant_idx] = 1'b1;
  end

  assign sel_rd   = rd_arr[grant_idx];
  assign sel_data = data_arr[grant_idx];

  // A grant to x0 still consumes the slot but must not reach the register file.
  always_comb begin
    ptr_d    = ptr_q;
    wen_d    = 1'b0;
    addr_d   = addr_q;
    result_d = result_q;
    if (grant_any) begin
      ptr_d = (grant_idx == PW'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      if (sel_rd != 5'd0) begin
        wen_d    = 1'b1;
        addr_d   = sel_rd;
        result_d = sel_data;
      end else begin
        addr_d   = 5'd0;
        result_d = '0;
      end
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      ptr_q    <= '0;
      wen_q    <= 1'b0;
      addr_q   <= 5'd0;
      result_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    pend_all = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) pend_all = pend_all | pend_arr[k];
    if (wen_q) pend_all[addr_q] = 1'b1;
    pend_all[0] = 1'b0;
  end

  assign pending_o = pend_all;
  assign rd_wen_o  = wen_q;
  assign rd_addr_o = addr_q;
  assign result_o  = result_q;

endmodule
